// File: rtl/fcc_pkg.sv
// Shared types and defaults for the frame capture controller.
// The write-port struct is sized by the package widths; the controller and
// arbiter exchange frame-buffer writes through it.
package fcc_pkg;

    localparam int FCC_FRAME_PIXELS = 307200;
    localparam int FCC_ADDR_W       = 19;
    localparam int FCC_DATA_W       = 16;
    localparam int FCC_CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } fcc_state_e;

    typedef struct packed {
        logic                  we;
        logic [FCC_ADDR_W-1:0] addr;
        logic [FCC_DATA_W-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Signal bundle between the capture controller and its neighbours:
// camera stream, host command/write path, frame-buffer write port and status.
// slave = controller side, master = the side driving camera/host inputs.
interface frame_capture_ctrl_if
    import fcc_pkg::*;
#(
    parameter int ADDR_W = FCC_ADDR_W,
    parameter int DATA_W = FCC_DATA_W,
    parameter int CNT_W  = FCC_CNT_W
);

    logic              cam_vsync_n;
    logic              cam_valid;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;

    logic              cmd_start;
    logic              cmd_continuous;
    logic              cmd_stop;

    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_gnt;

    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;

    logic              busy;
    logic              frame_done;
    logic              aborted;
    logic [CNT_W-1:0]  frame_count;

    modport slave (
        input  cam_vsync_n, cam_valid, cam_addr, cam_data,
        input  cmd_start, cmd_continuous, cmd_stop,
        input  host_req, host_addr, host_data,
        output host_gnt,
        output fb_we, fb_addr, fb_data,
        output busy, frame_done, aborted, frame_count
    );

    modport master (
        output cam_vsync_n, cam_valid, cam_addr, cam_data,
        output cmd_start, cmd_continuous, cmd_stop,
        output host_req, host_addr, host_data,
        input  host_gnt,
        input  fb_we, fb_addr, fb_data,
        input  busy, frame_done, aborted, frame_count
    );

endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter. The camera always wins and is never
// stalled; the host gets the port only in cycles with no camera write.
// The chosen write is registered once, so the RAM sees it one cycle later.
module fb_write_arbiter
    import fcc_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  cam_write,
    input  logic [FCC_ADDR_W-1:0] cam_addr,
    input  logic [FCC_DATA_W-1:0] cam_data,
    input  logic                  host_req,
    input  logic [FCC_ADDR_W-1:0] host_addr,
    input  logic [FCC_DATA_W-1:0] host_data,
    output logic                  host_gnt,
    output fb_wr_t                wr_p1
);

    fb_wr_t wr_p0;

    assign host_gnt = host_req & ~cam_write;

    // Pick the winner; address/data keep their previous value when idle.
    always_comb begin
        wr_p0    = wr_p1;
        wr_p0.we = 1'b0;
        if (cam_write) begin
            wr_p0.we   = 1'b1;
            wr_p0.addr = cam_addr;
            wr_p0.data = cam_data;
        end else if (host_gnt) begin
            wr_p0.we   = 1'b1;
            wr_p0.addr = host_addr;
            wr_p0.data = host_data;
        end
    end

    // p0 -> p1: registered write port.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_p1 <= '0;
        end else begin
            wr_p1 <= wr_p0;
        end
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller. Arms on host command, waits for the next
// vsync_n rising edge, then writes camera pixels into the frame buffer for
// one frame (single) or every frame until stopped (continuous). Host writes
// share the same RAM port and fill the gaps between camera pixels.
module frame_capture_ctrl
    import fcc_pkg::*;
#(
    parameter int FRAME_PIXELS = FCC_FRAME_PIXELS,
    parameter int ADDR_W       = FCC_ADDR_W,
    parameter int DATA_W       = FCC_DATA_W,
    parameter int CNT_W        = FCC_CNT_W
) (
    input  logic                 clk,
    input  logic                 arst_n,
    frame_capture_ctrl_if.slave  bus
);

    // Plain-bus state codes, numerically identical to the package enum.
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ARMED   = ST_ARMED;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              mode_q;
    logic              mode_d;
    logic              vsync_q;
    logic              sof;
    logic              cam_in_range;
    logic              cam_write;
    logic              last;
    logic              frame_done_q;
    logic              aborted_q;
    logic [CNT_W-1:0]  frame_count_q;

    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    fb_wr_t            wr_p1;

    assign cam_addr  = bus.cam_addr;
    assign cam_data  = bus.cam_data;
    assign host_addr = bus.host_addr;
    assign host_data = bus.host_data;

    // Frame start is the rising edge of the active-low vsync.
    assign sof          = ~vsync_q & bus.cam_vsync_n;
    // Addresses beyond the frame are dropped so they can never hit the RAM.
    assign cam_in_range = (32'(cam_addr) < 32'(FRAME_PIXELS));
    assign cam_write    = (state_q == S_CAPTURE) & bus.cam_valid & cam_in_range;
    assign last         = cam_write & (cam_addr == LAST_ADDR);

    // Next-state logic; stop has priority over start, and a frame that
    // completes in the stop cycle still counts as done.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start && !bus.cmd_stop) begin
                    state_d = S_ARMED;
                    mode_d  = bus.cmd_continuous;
                end
            end
            S_ARMED: begin
                if (bus.cmd_stop) begin
                    state_d = S_IDLE;
                end else if (sof) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A sof landing on the last pixel is not consumed here, so
                // the following frame is skipped.
                if (last) begin
                    state_d = (mode_q && !bus.cmd_stop) ? S_ARMED : S_IDLE;
                end else if (bus.cmd_stop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, mode and vsync history.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vsync_q <= bus.cam_vsync_n;
        end
    end

    // Status pulses and the completed-frame counter, aligned with fb_* output.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_done_q  <= 1'b0;
            aborted_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= last;
            aborted_q    <= (state_q == S_CAPTURE) & bus.cmd_stop & ~last;
            if (last) begin
                frame_count_q <= frame_count_q + CNT_W'(1);
            end
        end
    end

    fb_write_arbiter u_arb (
        .clk       (clk),
        .arst_n    (arst_n),
        .cam_write (cam_write),
        .cam_addr  (cam_addr),
        .cam_data  (cam_data),
        .host_req  (bus.host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_gnt  (bus.host_gnt),
        .wr_p1     (wr_p1)
    );

    assign bus.fb_we       = wr_p1.we;
    assign bus.fb_addr     = wr_p1.addr;
    assign bus.fb_data     = wr_p1.data;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_done  = frame_done_q;
    assign bus.aborted     = aborted_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl with a reduced frame size. A behavioural
// model tracks capture/arm flags and the expected write port each cycle.
module tb_frame_capture_ctrl;

    localparam int FP = 40;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic arst_n;

    frame_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    frame_capture_ctrl #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .CNT_W        (CW)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model
    bit            m_cap, m_arm, m_cont, m_vs, m_we, m_done, m_abort;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_cnt;

    int wr_seen, done_seen, abort_seen, exp_wr;
    bit host_on;
    bit gnt_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cap = 0; m_arm = 0; m_cont = 0; m_vs = 1; m_we = 0;
        m_done = 0; m_abort = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    endtask

    task automatic begin_seg();
        wr_seen = 0; done_seen = 0; abort_seen = 0; exp_wr = 0;
    endtask

    task automatic tick();
        bit cam_ok, gnt_exp, sof, last;
        @(negedge clk);
        cam_ok  = m_cap && (bus.cam_valid === 1'b1) && (bus.cam_addr < AW'(FP));
        gnt_exp = (bus.host_req === 1'b1) && !cam_ok;
        chk("host_gnt", 32'(bus.host_gnt), 32'(gnt_exp));
        chk("busy", 32'(bus.busy), 32'(m_cap || m_arm));
        gnt_last = (bus.host_gnt === 1'b1);
        if (cam_ok) begin
            m_we = 1; m_addr = bus.cam_addr; m_data = bus.cam_data;
        end else if (gnt_exp) begin
            m_we = 1; m_addr = bus.host_addr; m_data = bus.host_data;
        end else begin
            m_we = 0;
        end
        if (m_we) exp_wr++;
        sof  = !m_vs && bus.cam_vsync_n;
        m_vs = bus.cam_vsync_n;
        last = cam_ok && (bus.cam_addr == AW'(FP - 1));
        m_done  = last;
        m_abort = m_cap && bus.cmd_stop && !last;
        if (last) m_cnt = m_cnt + 1'b1;
        if (m_cap) begin
            if (last) begin
                m_cap = 0;
                m_arm = m_cont && !bus.cmd_stop;
            end else if (bus.cmd_stop) begin
                m_cap = 0;
            end
        end else if (m_arm) begin
            if (bus.cmd_stop) m_arm = 0;
            else if (sof) begin m_arm = 0; m_cap = 1; end
        end else if (bus.cmd_start && !bus.cmd_stop) begin
            m_arm = 1; m_cont = bus.cmd_continuous;
        end
        @(posedge clk);
        #1;
        chk("fb_we", 32'(bus.fb_we), 32'(m_we));
        chk("fb_addr", 32'(bus.fb_addr), 32'(m_addr));
        chk("fb_data", 32'(bus.fb_data), 32'(m_data));
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        chk("aborted", 32'(bus.aborted), 32'(m_abort));
        chk("frame_count", 32'(bus.frame_count), 32'(m_cnt));
        if (bus.fb_we === 1'b1) wr_seen++;
        if (bus.frame_done === 1'b1) done_seen++;
        if (bus.aborted === 1'b1) abort_seen++;
    endtask

    // host holds its request and only moves on once granted
    task automatic host_refresh();
        if (host_on && gnt_last) begin
            bus.host_addr = AW'($urandom_range(FP - 1, 0));
            bus.host_data = DW'($urandom);
        end
    endtask

    task automatic cyc();
        tick();
        host_refresh();
    endtask

    task automatic pulse_start(input bit cont);
        bus.cmd_start = 1; bus.cmd_continuous = cont;
        cyc();
        bus.cmd_start = 0; bus.cmd_continuous = 0;
    endtask

    task automatic pulse_stop();
        bus.cmd_stop = 1;
        cyc();
        bus.cmd_stop = 0;
    endtask

    task automatic vsync_pulse();
        bus.cam_vsync_n = 0;
        cyc();
        bus.cam_vsync_n = 1;
        cyc();
    endtask

    task automatic stream(input int from, input int upto, input int gap_pct,
                          input int stop_at, input bit data_is_addr);
        for (int a = from; a < upto; a++) begin
            if (int'($urandom_range(99, 0)) < gap_pct) begin
                bus.cam_valid = 0;
                bus.cam_addr  = AW'($urandom_range(FP - 1, 0));
                cyc();
            end
            bus.cam_valid = 1;
            bus.cam_addr  = AW'(a);
            bus.cam_data  = data_is_addr ? DW'(a) : DW'($urandom);
            bus.cmd_stop  = (a == stop_at);
            cyc();
            bus.cam_valid = 0;
            bus.cmd_stop  = 0;
        end
    endtask

    initial begin
        arst_n = 0;
        bus.cam_vsync_n = 1; bus.cam_valid = 0; bus.cam_addr = '0; bus.cam_data = '0;
        bus.cmd_start = 0; bus.cmd_continuous = 0; bus.cmd_stop = 0;
        bus.host_req = 0; bus.host_addr = '0; bus.host_data = '0;
        host_on = 0; gnt_last = 0;
        model_reset();
        begin_seg();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
        chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        chk("rst_fb_data", 32'(bus.fb_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_aborted", 32'(bus.aborted), 32'd0);
        chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
        arst_n = 1;
        cyc();

        // single frame, data = address; following frame not written
        begin_seg();
        pulse_start(0);
        cyc();
        vsync_pulse();
        stream(0, FP, 30, -1, 1);
        cyc();
        chk("single_writes", 32'(wr_seen), 32'(FP));
        chk("single_done", 32'(done_seen), 32'd1);
        chk("single_count", 32'(bus.frame_count), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd0);
        begin_seg();
        vsync_pulse();
        stream(0, FP, 0, -1, 1);
        chk("single_next_writes", 32'(wr_seen), 32'd0);

        // extra start while armed, pixels before sof are ignored
        begin_seg();
        pulse_start(0);
        stream(0, 8, 0, -1, 0);
        pulse_start(1);
        stream(8, 12, 0, -1, 0);
        chk("armed_writes", 32'(wr_seen), 32'd0);
        chk("armed_busy", 32'(bus.busy), 32'd1);
        vsync_pulse();
        stream(0, FP, 20, -1, 0);
        cyc();
        chk("armed_frame_writes", 32'(wr_seen), 32'(FP));
        chk("armed_count", 32'(bus.frame_count), 32'd2);
        chk("armed_single_busy", 32'(bus.busy), 32'd0);

        // continuous: three frames, stop in the fourth at address 10
        begin_seg();
        pulse_start(1);
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            stream(0, FP, 10, -1, 0);
        end
        vsync_pulse();
        stream(0, 11, 10, 10, 0);
        stream(11, FP, 0, -1, 0);
        cyc();
        chk("cont_writes", 32'(wr_seen), 32'(3 * FP + 11));
        chk("cont_done", 32'(done_seen), 32'd3);
        chk("cont_aborted", 32'(abort_seen), 32'd1);
        chk("cont_count", 32'(bus.frame_count), 32'd5);
        chk("cont_busy", 32'(bus.busy), 32'd0);

        // asynchronous reset in the middle of a capture
        pulse_start(0);
        vsync_pulse();
        stream(0, 10, 0, -1, 0);
        bus.cam_valid = 1; bus.cam_addr = AW'(10); bus.cam_data = DW'(16'h1234);
        arst_n = 0;
        #1;
        model_reset();
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_fb_we", 32'(bus.fb_we), 32'd0);
        chk("arst_count", 32'(bus.frame_count), 32'd0);
        chk("arst_done", 32'(bus.frame_done), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("arst_hold_busy", 32'(bus.busy), 32'd0);
            chk("arst_hold_fb_we", 32'(bus.fb_we), 32'd0);
            chk("arst_hold_done", 32'(bus.frame_done), 32'd0);
        end
        arst_n = 1;
        bus.cam_valid = 0;
        begin_seg();
        stream(11, FP, 0, -1, 0);
        chk("arst_after_writes", 32'(wr_seen), 32'd0);
        chk("arst_after_done", 32'(done_seen), 32'd0);

        // host held during capture, camera gated ~50%
        begin_seg();
        host_on = 1;
        bus.host_req  = 1;
        bus.host_addr = AW'($urandom_range(FP - 1, 0));
        bus.host_data = DW'($urandom);
        pulse_start(0);
        vsync_pulse();
        stream(0, FP, 50, -1, 0);
        bus.host_req = 0;
        host_on = 0;
        cyc();
        chk("host_writes", 32'(wr_seen), 32'(exp_wr));
        chk("host_done", 32'(done_seen), 32'd1);
        chk("host_count", 32'(bus.frame_count), 32'd1);

        // stop on the last pixel: frame completes, no abort
        begin_seg();
        pulse_start(0);
        vsync_pulse();
        stream(0, FP, 20, FP - 1, 0);
        cyc();
        chk("stoplast_done", 32'(done_seen), 32'd1);
        chk("stoplast_aborted", 32'(abort_seen), 32'd0);
        chk("stoplast_count", 32'(bus.frame_count), 32'd2);
        chk("stoplast_busy", 32'(bus.busy), 32'd0);

        // continuous: sof on the last pixel skips the next frame
        begin_seg();
        pulse_start(1);
        vsync_pulse();
        stream(0, FP - 2, 0, -1, 0);
        bus.cam_vsync_n = 0;
        stream(FP - 2, FP - 1, 0, -1, 0);
        bus.cam_vsync_n = 1;
        stream(FP - 1, FP, 0, -1, 0);
        stream(0, FP, 0, -1, 0);
        vsync_pulse();
        stream(0, FP, 0, -1, 0);
        pulse_stop();
        cyc();
        chk("sofl_writes", 32'(wr_seen), 32'(2 * FP));
        chk("sofl_done", 32'(done_seen), 32'd2);
        chk("sofl_count", 32'(bus.frame_count), 32'd4);

        // start and stop together: stop wins
        begin_seg();
        bus.cmd_start = 1; bus.cmd_stop = 1;
        cyc();
        bus.cmd_start = 0; bus.cmd_stop = 0;
        vsync_pulse();
        stream(0, 5, 0, -1, 0);
        chk("startstop_writes", 32'(wr_seen), 32'd0);

        // out-of-range camera address is dropped; host takes the port
        begin_seg();
        pulse_start(0);
        vsync_pulse();
        bus.host_req = 1; bus.host_addr = AW'(7); bus.host_data = DW'(16'hBEEF);
        bus.cam_valid = 1; bus.cam_addr = AW'(FP + 3); bus.cam_data = DW'(16'h0DD0);
        cyc();
        chk("oor_fb_addr", 32'(bus.fb_addr), 32'd7);
        chk("oor_fb_data", 32'(bus.fb_data), 32'hBEEF);
        bus.host_req = 0; bus.cam_valid = 0;
        pulse_stop();
        cyc();
        chk("oor_writes", 32'(wr_seen), 32'd1);
        chk("oor_aborted", 32'(abort_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
